// File: rtl/mips_defs.sv
// ============================================================================
// Module   : mips_defs (package)
// Purpose  : Shared definitions for the execute-stage divider: FSM state
//            encoding and the quotient value produced on divide-by-zero.
// Contents : DIV_IDLE / DIV_BUSY / DIV_DONE  - 2-bit divider state encoding
//            DIV_ZERO_LO                     - LO result for a zero divisor
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_defs;

    localparam int DATA_W = 32;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_BUSY = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    // Quotient reported when the divisor is zero (all ones).
    localparam logic [DATA_W-1:0] DIV_ZERO_LO = '1;

endpackage : mips_defs

`default_nettype wire

// File: rtl/div_unit_step.sv
// ============================================================================
// Module   : div_unit_step
// Purpose  : One combinational iteration of a radix-2 restoring divider.
//            Shifts {rem,quo} left by one, trial-subtracts the divisor with a
//            WIDTH+1-bit subtract and keeps the difference when it does not
//            go negative, shifting in the matching quotient bit.
// Ports    : i_rem     - partial remainder
//            i_quo     - partially shifted dividend / quotient bits
//            i_divisor - divisor magnitude
//            o_rem     - partial remainder after this iteration
//            o_quo     - quotient register after this iteration
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;
    logic           w_borrow;

    // The remainder is always below the divisor, so the shifted value is
    // below twice the divisor and the top bit of the difference is a true sign.
    assign w_shifted = {i_rem, i_quo[WIDTH-1]};
    assign w_diff    = w_shifted - {1'b0, i_divisor};
    assign w_borrow  = w_diff[WIDTH];

    assign o_rem = w_borrow ? w_shifted[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign o_quo = {i_quo[WIDTH-2:0], ~w_borrow};

endmodule : div_unit_step

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// Module   : div_unit
// Purpose  : Iterative radix-2 restoring divider for MIPS DIV/DIVU in the
//            execute stage. Produces quotient (lo) and remainder (hi) for the
//            HI/LO write path and a stall request for the hazard unit.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            startE        - DIV/DIVU valid in E
//            signed_divE   - 1 = DIV (signed), 0 = DIVU
//            annulE        - abort the current operation
//            stall_ext     - external E/M hold, keeps results in DONE
//            a, b          - dividend, divisor
//            div_stallE    - combinational stall request to hazard unit
//            ready         - result valid this cycle
//            hi, lo        - remainder, quotient
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit
    import mips_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic             signed_divE,
    input  logic             annulE,
    input  logic             stall_ext,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             div_stallE,
    output logic             ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_divisor;
    logic             r_negQuo;
    logic             r_negRem;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_ready;

    logic             w_aNeg;
    logic             w_bNeg;
    logic [WIDTH-1:0] w_absA;
    logic [WIDTH-1:0] w_absB;
    logic             w_bZero;
    logic [WIDTH-1:0] w_stepRem;
    logic [WIDTH-1:0] w_stepQuo;
    logic [WIDTH-1:0] w_finalQuo;
    logic [WIDTH-1:0] w_finalRem;

    // Operand magnitudes; sign bits only matter for DIV.
    assign w_aNeg  = signed_divE & a[WIDTH-1];
    assign w_bNeg  = signed_divE & b[WIDTH-1];
    assign w_absA  = w_aNeg ? (~a + 1'b1) : a;
    assign w_absB  = w_bNeg ? (~b + 1'b1) : b;
    assign w_bZero = (b == '0);

    div_unit_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_stepRem),
        .o_quo     (w_stepQuo)
    );

    // Sign fix-up on the last iteration's output. Negating 0x80000000 wraps
    // to itself, which gives the required MIN_INT / -1 overflow result.
    assign w_finalQuo = r_negQuo ? (~w_stepQuo + 1'b1) : w_stepQuo;
    assign w_finalRem = r_negRem ? (~w_stepRem + 1'b1) : w_stepRem;

    always_comb begin
        div_stallE = 1'b0;
        case (r_state)
            DIV_IDLE: div_stallE = startE & ~annulE;
            DIV_BUSY: div_stallE = ~annulE;
            default:  div_stallE = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= DIV_IDLE;
            r_count   <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_negQuo  <= 1'b0;
            r_negRem  <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_ready   <= 1'b0;
        end else if (annulE) begin
            // Abort from any state; hi/lo keep the last completed result.
            r_state <= DIV_IDLE;
            r_count <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    r_ready <= 1'b0;
                    if (startE) begin
                        if (w_bZero) begin
                            r_lo    <= WIDTH'(DIV_ZERO_LO);
                            r_hi    <= a;
                            r_ready <= 1'b1;
                            r_state <= DIV_DONE;
                        end else begin
                            r_quo     <= w_absA;
                            r_divisor <= w_absB;
                            r_rem     <= '0;
                            r_negQuo  <= w_aNeg ^ w_bNeg;
                            r_negRem  <= w_aNeg;
                            r_count   <= '0;
                            r_state   <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    r_rem   <= w_stepRem;
                    r_quo   <= w_stepQuo;
                    r_count <= r_count + CNT_W'(1);
                    if (r_count == LAST_CNT) begin
                        r_lo    <= w_finalQuo;
                        r_hi    <= w_finalRem;
                        r_ready <= 1'b1;
                        r_state <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    // Results stay on the outputs while the pipeline is held.
                    if (!stall_ext) begin
                        r_ready <= 1'b0;
                        r_state <= DIV_IDLE;
                    end
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= DIV_IDLE;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule : div_unit

`default_nettype wire
